reg_read: RTL and testbench

REG_READ -- requirements
Module: reg_read

---
 rtl/regfile_pkg.sv | 15 +
 rtl/reg_read_sel.sv | 35 +++
 rtl/reg_read.sv | 106 ++++++++++
 tb/tb_reg_read.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry and the read-buffer
// occupancy encoding used by the register read stage.
package regfile_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/reg_read_sel.sv
// Per-port operand select: index 0 reads as zero, a same-cycle write to the
// index is forwarded, otherwise the register slice from q is used.
module reg_read_sel
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic [NUM_REGS*DATA_W-1:0] q_i,
  input  logic [ADDR_W-1:0]          idx_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          wreg_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          data_o
);

  logic [DATA_W-1:0] slice;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_i == ADDR_W'(i)) slice = q_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    if (idx_i == '0)                      data_o = '0;
    else if (we_i && (wreg_i == idx_i))   data_o = wdata_i;
    else                                  data_o = slice;
  end

endmodule

// File: rtl/reg_read.sv
// Register read stage: captures both operands on accept and holds them in a
// two-entry (output + skid) buffer so rd_ready never depends on out_ready.
module reg_read
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic [NUM_REGS*DATA_W-1:0] q,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_W-1:0]          ctrl_writeReg,
  input  logic [DATA_W-1:0]          data_writeReg,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [ADDR_W-1:0]          ctrl_readRegA,
  input  logic [ADDR_W-1:0]          ctrl_readRegB,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data_readRegA,
  output logic [DATA_W-1:0]          data_readRegB
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] out_a_q, out_b_q, skid_a_q, skid_b_q;
  logic              accept, drain;
  logic              load_out_new, load_out_skid, load_skid;

  reg_read_sel #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_a (
    .q_i(q), .idx_i(ctrl_readRegA), .we_i(ctrl_writeEnable),
    .wreg_i(ctrl_writeReg), .wdata_i(data_writeReg), .data_o(sel_a)
  );

  reg_read_sel #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_b (
    .q_i(q), .idx_i(ctrl_readRegB), .we_i(ctrl_writeEnable),
    .wreg_i(ctrl_writeReg), .wdata_i(data_writeReg), .data_o(sel_b)
  );

  assign accept = rd_valid && rd_ready;
  assign drain  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state_q <= ST_EMPTY;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      ST_EMPTY: if (accept) begin
        state_d      = ST_ONE;
        load_out_new = 1'b1;
      end
      ST_ONE: begin
        if (accept && drain)  load_out_new = 1'b1;
        else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (drain)   state_d = ST_EMPTY;
      end
      ST_TWO: if (drain) begin
        state_d       = ST_ONE;
        load_out_skid = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid     = (state_q != ST_EMPTY);
    rd_ready      = (state_q != ST_TWO);
    data_readRegA = out_a_q;
    data_readRegB = out_b_q;
  end

  // Reset clears buffered operands so nothing stale is visible afterwards.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      out_a_q  <= '0;
      out_b_q  <= '0;
      skid_a_q <= '0;
      skid_b_q <= '0;
    end else begin
      if (load_out_new) begin
        out_a_q <= sel_a;
        out_b_q <= sel_b;
      end else if (load_out_skid) begin
        out_a_q <= skid_a_q;
        out_b_q <= skid_b_q;
      end
      if (load_skid) begin
        skid_a_q <= sel_a;
        skid_b_q <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_read.sv
// Directed self-checking bench for reg_read: reset, select/bypass rules,
// skid-buffer backpressure ordering, mid-operation reset and snapshot hold.
module tb_reg_read;

  logic           clock;
  logic           ctrl_reset_n;
  logic [1023:0]  q;
  logic           ctrl_writeEnable;
  logic [4:0]     ctrl_writeReg;
  logic [31:0]    data_writeReg;
  logic           rd_valid;
  logic           rd_ready;
  logic [4:0]     ctrl_readRegA;
  logic [4:0]     ctrl_readRegB;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    data_readRegA;
  logic [31:0]    data_readRegB;

  int n_cmp = 0;
  int n_err = 0;

  reg_read dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .q(q),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_q(input int idx, input logic [31:0] val);
    q[idx*32 +: 32] = val;
  endtask

  task automatic idle_drain();
    rd_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready got=%b exp=1", rd_ready); end
    n_cmp++; if (data_readRegA !== 32'h0) begin n_err++; $display("FAIL reset_A got=%h exp=0", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0) begin n_err++; $display("FAIL reset_B got=%h exp=0", data_readRegB); end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_basic();
    set_q(7, 32'h0000_00AA);
    out_ready     = 1'b1;
    rd_valid      = 1'b1;
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd0;
    step();
    rd_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_cmp++; if (data_readRegA !== 32'h0000_00AA) begin n_err++; $display("FAIL basic_A got=%h exp=000000aa", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0) begin n_err++; $display("FAIL basic_B got=%h exp=0", data_readRegB); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_bypass();
    set_q(5, 32'h0);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'h1234_5678;
    rd_valid         = 1'b1;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd7;
    step();
    rd_valid         = 1'b0;
    ctrl_writeEnable = 1'b0;
    n_cmp++; if (data_readRegA !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_A got=%h exp=12345678", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0000_00AA) begin n_err++; $display("FAIL bypass_B_nohit got=%h exp=000000aa", data_readRegB); end
    idle_drain();
  endtask

  task automatic test_zero_bypass();
    set_q(0, 32'hDEAD_BEEF);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hFFFF_FFFF;
    rd_valid         = 1'b1;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    step();
    rd_valid         = 1'b0;
    ctrl_writeEnable = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    n_cmp++; if (data_readRegA !== 32'h0) begin n_err++; $display("FAIL zero_A got=%h exp=0", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0) begin n_err++; $display("FAIL zero_B got=%h exp=0", data_readRegB); end
    idle_drain();
  endtask

  task automatic test_back_to_back();
    set_q(1, 32'h0000_0101);
    set_q(2, 32'h0000_0202);
    set_q(3, 32'h0000_0303);
    ctrl_readRegB = 5'd0;
    out_ready     = 1'b0;
    rd_valid      = 1'b1;
    ctrl_readRegA = 5'd1;
    step();
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after1 got=%b exp=1", rd_ready); end
    ctrl_readRegA = 5'd2;
    step();
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after2 got=%b exp=0", rd_ready); end
    n_cmp++; if (data_readRegA !== 32'h0000_0101) begin n_err++; $display("FAIL b2b_head got=%h exp=00000101", data_readRegA); end
    ctrl_readRegA = 5'd3;
    step();
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_hold got=%b exp=0", rd_ready); end
    n_cmp++; if (data_readRegA !== 32'h0000_0101) begin n_err++; $display("FAIL b2b_head_hold got=%h exp=00000101", data_readRegA); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (data_readRegA !== 32'h0000_0202) begin n_err++; $display("FAIL b2b_second got=%h exp=00000202", data_readRegA); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_reopen got=%b exp=1", rd_ready); end
    step();
    rd_valid = 1'b0;
    n_cmp++; if (data_readRegA !== 32'h0000_0303) begin n_err++; $display("FAIL b2b_third got=%h exp=00000303", data_readRegA); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_third_valid got=%b exp=1", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready     = 1'b0;
    rd_valid      = 1'b1;
    ctrl_readRegA = 5'd1;
    ctrl_readRegB = 5'd2;
    step();
    step();
    rd_valid = 1'b0;
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_full got=%b exp=0", rd_ready); end
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=1", rd_ready); end
    n_cmp++; if (data_readRegA !== 32'h0) begin n_err++; $display("FAIL rst_mid_A got=%h exp=0", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0) begin n_err++; $display("FAIL rst_mid_B got=%h exp=0", data_readRegB); end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    out_ready    = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale got=%b exp=0", out_valid); end
    // First accept on the first edge after release.
    ctrl_reset_n = 1'b0;
    #2;
    ctrl_reset_n  = 1'b1;
    rd_valid      = 1'b1;
    ctrl_readRegA = 5'd2;
    ctrl_readRegB = 5'd0;
    step();
    rd_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_accept got=%b exp=1", out_valid); end
    n_cmp++; if (data_readRegA !== 32'h0000_0202) begin n_err++; $display("FAIL rst_first_A got=%h exp=00000202", data_readRegA); end
    idle_drain();
  endtask

  task automatic test_snapshot();
    set_q(3, 32'h0000_0011);
    out_ready     = 1'b0;
    rd_valid      = 1'b1;
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd7;
    step();
    rd_valid = 1'b0;
    set_q(3, 32'h0000_0022);
    ctrl_readRegA    = 5'd9;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h5555_5555;
    step();
    step();
    ctrl_writeEnable = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL snap_valid got=%b exp=1", out_valid); end
    n_cmp++; if (data_readRegA !== 32'h0000_0011) begin n_err++; $display("FAIL snap_A got=%h exp=00000011", data_readRegA); end
    n_cmp++; if (data_readRegB !== 32'h0000_00AA) begin n_err++; $display("FAIL snap_B got=%h exp=000000aa", data_readRegB); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL snap_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    q                = '0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    rd_valid         = 1'b0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    out_ready        = 1'b0;
    test_reset();
    step();
    test_basic();
    test_bypass();
    test_zero_bypass();
    test_back_to_back();
    test_reset_mid();
    test_snapshot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
